// File: rtl/npu_pkg.sv
// Shared NPU fixed-point types and constants: Q8.8 data format and MAC engine states.
package npu_pkg;

  localparam int unsigned FRAC_BITS = 8;
  localparam int unsigned DATA_BITS = 16;

  typedef logic signed [15:0] q8_8_t;

  localparam q8_8_t Q8_8_MAX = 16'sh7fff;
  localparam q8_8_t Q8_8_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    OUT
  } mac_state_e;

endpackage

// File: rtl/q_round_sat.sv
// Combinational requantiser: round-half-up, arithmetic shift right by SHIFT,
// then clamp to the signed OUT_W range.
module q_round_sat #(
  parameter int unsigned IN_W  = 40,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned SHIFT = 8
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout
);

  localparam logic [IN_W:0] ROUND =
    {{(IN_W + 1 - SHIFT){1'b0}}, 1'b1, {(SHIFT - 1){1'b0}}};
  localparam logic signed [IN_W:0] MAX_V =
    {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [IN_W:0] MIN_V =
    {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

  logic signed [IN_W:0] rounded;
  logic signed [IN_W:0] shifted;

  always_comb begin
    // One guard bit keeps the rounding add from ever wrapping.
    rounded = $signed({din[IN_W-1], din}) + $signed(ROUND);
    shifted = rounded >>> SHIFT;
    if (shifted > MAX_V) begin
      dout = MAX_V[OUT_W-1:0];
    end else if (shifted < MIN_V) begin
      dout = MIN_V[OUT_W-1:0];
    end else begin
      dout = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// Signed Q8.8 multiply-accumulate engine for one neuron: bias + sum(a*b),
// rounded and saturated back to Q8.8 for the ReLU stage.
module neuron_mac
  import npu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_BITS,
  parameter int unsigned FRAC   = FRAC_BITS,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] bias,
  input  logic              in_val,
  output logic              in_rdy,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_val,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  mac_state_e                state;
  logic [LEN_W-1:0]          cnt;
  logic signed [ACC_W-1:0]   acc;
  logic signed [2*DATA_W-1:0] prod_q;
  logic                      prod_v;

  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   bias_ext;
  logic signed [ACC_W-1:0]   drain_sum;
  logic [DATA_W-1:0]         rs_out;
  logic                      accept;

  always_comb begin
    prod_ext  = {{(ACC_W - 2*DATA_W){prod_q[2*DATA_W-1]}}, prod_q};
    bias_ext  = {{(ACC_W - DATA_W - FRAC){bias[DATA_W-1]}}, bias, {FRAC{1'b0}}};
    drain_sum = acc + (prod_v ? prod_ext : '0);
    accept    = in_val & in_rdy;
  end

  q_round_sat #(
    .IN_W  (ACC_W),
    .OUT_W (DATA_W),
    .SHIFT (FRAC)
  ) u_round_sat (
    .din  (drain_sum),
    .dout (rs_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      prod_q   <= '0;
      prod_v   <= 1'b0;
      out_data <= '0;
      out_val  <= 1'b0;
      in_rdy   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      // Product pipeline drains into acc every cycle except DRAIN, where the
      // pending product is folded in combinationally instead.
      if (prod_v && state != DRAIN) begin
        acc <= acc + prod_ext;
      end
      prod_v <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start) begin
            cnt  <= len;
            acc  <= bias_ext;
            busy <= 1'b1;
            if (len != '0) begin
              state  <= ACCUM;
              in_rdy <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            prod_q <= $signed({{DATA_W{in_a[DATA_W-1]}}, in_a}) *
                      $signed({{DATA_W{in_b[DATA_W-1]}}, in_b});
            prod_v <= 1'b1;
            cnt    <= cnt - LEN_W'(1);
            if (cnt == LEN_W'(1)) begin
              state  <= DRAIN;
              in_rdy <= 1'b0;
            end
          end
        end
        DRAIN: begin
          out_data <= rs_out;
          out_val  <= 1'b1;
          state    <= OUT;
        end
        OUT: begin
          if (out_rdy) begin
            out_val <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
